controle_mult_serial: RTL and testbench

- Moore-style controller that sequences a shift-and-add serial multiplier datapath.
- The datapath holds the operand registers A and B, an accumulator, a shift register and a final result register.
- The controller accepts a start/done handshake from the upper level and drives the datapath enables.
- It consumes only the multiplier LSB from the datapath. N iterations are counted internally.

---
 rtl/controle_mult_serial_pkg.sv | 22 ++
 rtl/controle_mult_serial_contador_bits.sv | 37 +++
 rtl/controle_mult_serial.sv | 82 ++++++++
 tb/tb_controle_mult_serial.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/controle_mult_serial_pkg.sv
// Shared definitions for the serial shift-and-add multiplier controller:
// state encoding and the iteration counter width.
package mult_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_CHECK = 3'd2;
  localparam logic [2:0] ST_ADD   = 3'd3;
  localparam logic [2:0] ST_SHIFT = 3'd4;
  localparam logic [2:0] ST_FIM   = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int N_DEF = 8;
  localparam int CNT_W = cnt_width(N_DEF);

endpackage

// File: rtl/controle_mult_serial_contador_bits.sv
// Iteration counter: synchronous clear and enable, flags the last iteration.
module contador_bits
  import mult_pkg::*;
#(
  parameter int N = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic term
);

  localparam int W = cnt_width(N);
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en)
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign term = (cnt_q == LAST);

endmodule

// File: rtl/controle_mult_serial.sv
// Moore controller sequencing a shift-and-add serial multiplier datapath;
// outputs are decoded from the state register only.
module controle_mult_serial
  import mult_pkg::*;
#(
  parameter int N = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic lsb_b,
  output logic hab_reg_ab,
  output logic clr_acc,
  output logic hab_acc,
  output logic desloca,
  output logic hab_reg_fim,
  output logic busy,
  output logic done
);

  logic [2:0] state_q;
  logic [2:0] state_d;
  logic       cnt_clr;
  logic       cnt_en;
  logic       cnt_term;

  contador_bits #(.N(N)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .term (cnt_term)
  );

  assign cnt_clr = (state_q == ST_LOAD);
  assign cnt_en  = (state_q == ST_SHIFT) && !cnt_term;

  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE:  state_d = start ? ST_LOAD : ST_IDLE;
      ST_LOAD:  state_d = ST_CHECK;
      ST_CHECK: state_d = lsb_b ? ST_ADD : ST_SHIFT;
      ST_ADD:   state_d = ST_SHIFT;
      ST_SHIFT: state_d = cnt_term ? ST_FIM : ST_CHECK;
      ST_FIM:   state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  // Decode is purely from state_q so an async reset clears outputs at once.
  always_comb begin
    hab_reg_ab  = 1'b0;
    clr_acc     = 1'b0;
    hab_acc     = 1'b0;
    desloca     = 1'b0;
    hab_reg_fim = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (state_q)
      ST_LOAD: begin
        hab_reg_ab = 1'b1;
        clr_acc    = 1'b1;
      end
      ST_CHECK: ;
      ST_ADD:   hab_acc     = 1'b1;
      ST_SHIFT: desloca     = 1'b1;
      ST_FIM:   hab_reg_fim = 1'b1;
      ST_DONE:  done        = 1'b1;
      default:  busy        = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_controle_mult_serial.sv
// Bench for controle_mult_serial with N=4 driving a small multiplier datapath.
module tb_controle_mult_serial;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst, start, lsb_b;
  logic hab_reg_ab, clr_acc, hab_acc, desloca, hab_reg_fim, busy, done;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [3:0] a_op, b_op;
  logic [3:0] a_r, b_sr;
  logic [4:0] acc;
  logic [7:0] fim_r;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  controle_mult_serial #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .lsb_b       (lsb_b),
    .hab_reg_ab  (hab_reg_ab),
    .clr_acc     (clr_acc),
    .hab_acc     (hab_acc),
    .desloca     (desloca),
    .hab_reg_fim (hab_reg_fim),
    .busy        (busy),
    .done        (done)
  );

  // Reference datapath the controller sequences.
  always @(posedge clk) begin
    if (hab_reg_ab) begin
      a_r  <= a_op;
      b_sr <= b_op;
    end
    if (clr_acc)
      acc <= '0;
    else if (hab_acc)
      acc <= acc + {1'b0, a_r};
    if (desloca)
      {acc, b_sr} <= {acc, b_sr} >> 1;
    if (hab_reg_fim)
      fim_r <= {acc[3:0], b_sr};
  end
  assign lsb_b = b_sr[0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] outs();
    return {hab_reg_ab, clr_acc, hab_acc, desloca, hab_reg_fim, busy, done};
  endfunction

  task automatic run_op(input string tag, input logic [3:0] a_in, input logic [3:0] b_in,
                        input int exp_add, input int exp_done, input bit hold,
                        input bit pulse, input logic [7:0] exp_prod, output int done_abs);
    int n_ab, n_add, n_sh, n_busy, n_done, fim_c, done_c, ab_c, bad;
    n_ab = 0; n_add = 0; n_sh = 0; n_busy = 0; n_done = 0;
    fim_c = -1; done_c = -1; ab_c = -1; bad = 0; done_abs = -1;
    @(negedge clk);
    chk({tag, "_idle_busy"}, busy, 0);
    a_op = a_in;
    b_op = b_in;
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (hab_reg_ab) begin n_ab++; if (ab_c < 0) ab_c = c; end
      if (hab_acc) n_add++;
      if (desloca) n_sh++;
      if (busy) n_busy++;
      if (hab_reg_fim) fim_c = c;
      if (clr_acc !== hab_reg_ab) bad++;
      if ($countones({hab_reg_ab, hab_acc, desloca, hab_reg_fim}) > 1) bad++;
      if (!hold) start = pulse ? (c % 3 == 0) : 1'b0;
      if (done) begin
        n_done++;
        done_c = c;
        done_abs = cyc;
        break;
      end
    end
    if (!hold) start = 1'b0;
    chk({tag, "_done_cycle"}, done_c, exp_done);
    chk({tag, "_fim_cycle"}, fim_c, exp_done - 1);
    chk({tag, "_ab_cycle"}, ab_c, 1);
    chk({tag, "_ab_count"}, n_ab, 1);
    chk({tag, "_add_count"}, n_add, exp_add);
    chk({tag, "_shift_count"}, n_sh, N);
    chk({tag, "_busy_count"}, n_busy, exp_done);
    chk({tag, "_onehot"}, bad, 0);
    chk({tag, "_product"}, fim_r, exp_prod);
    if (!hold) begin
      @(negedge clk);
      chk({tag, "_after_idle"}, {busy, done, hab_reg_ab}, 0);
    end
  endtask

  initial begin
    int d0, d1, d2, seen, guard, dummy;
    rst = 1'b0;
    start = 1'b0;
    a_op = '0;
    b_op = '0;
    #2 rst = 1'b1;
    #1 chk("reset_outs", outs(), 0);
    repeat (2) @(negedge clk);
    chk("reset_held", outs(), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_no_start", outs(), 0);

    run_op("op1011", 4'd13, 4'b1011, 3, 14, 0, 0, 8'd143, dummy);
    run_op("op0000", 4'd9, 4'b0000, 0, 11, 0, 0, 8'd0, dummy);
    run_op("op1111", 4'd15, 4'b1111, 4, 15, 0, 0, 8'd225, dummy);
    run_op("pulse", 4'd6, 4'b0101, 2, 13, 0, 1, 8'd30, dummy);
    repeat (3) begin
      @(negedge clk);
      chk("pulse_no_restart", {busy, hab_reg_ab}, 0);
    end

    run_op("b2b0", 4'd3, 4'b0000, 0, 11, 1, 0, 8'd0, d0);
    run_op("b2b1", 4'd5, 4'b0000, 0, 11, 1, 0, 8'd0, d1);
    run_op("b2b2", 4'd7, 4'b0000, 0, 11, 1, 0, 8'd0, d2);
    start = 1'b0;
    chk("b2b_space1", d1 - d0, 12);
    chk("b2b_space2", d2 - d1, 12);
    repeat (2) @(negedge clk);

    a_op = 4'd2;
    b_op = 4'b1011;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    seen = 0;
    guard = 0;
    while (seen < 2 && guard < 30) begin
      if (hab_acc) seen++;
      if (seen < 2) begin
        @(negedge clk);
        guard++;
      end
    end
    chk("rst_mid_reached_add2", seen, 2);
    #2 rst = 1'b1;
    #1 chk("rst_mid_outs", outs(), 0);
    @(negedge clk);
    chk("rst_mid_held", outs(), 0);
    rst = 1'b0;
    run_op("after_rst", 4'd7, 4'b1011, 3, 14, 0, 0, 8'd77, dummy);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
